// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: stage-3 writeback (no back-pressure) versus a
// long-latency unit parked in a one-entry hold buffer, with starvation stall and squash.
module wb_port_arbiter #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned SEL_W        = 5,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_we,
   input  logic [SEL_W-1:0]  a_wsel,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              b_valid,
   input  logic [SEL_W-1:0]  b_wsel,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ready,
   output logic              rf_we,
   output logic [SEL_W-1:0]  rf_wsel,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              pipe_stall,
   output logic              hold_valid,
   output logic [SEL_W-1:0]  hold_wsel,
   output logic              squash
);

   localparam logic [CNT_W:0] LIMIT = STARVE_LIMIT[CNT_W:0];

   logic [DATA_W-1:0] hold_data;
   logic [CNT_W-1:0]  wait_cnt;
   logic [CNT_W:0]    wait_inc;

   logic              we_n, stall_n, squash_n, hv_n, b_xfer;
   logic [SEL_W-1:0]  wsel_n, hsel_n;
   logic [DATA_W-1:0] wdata_n, hdata_n;
   logic [CNT_W-1:0]  cnt_n;

   assign b_ready  = !hold_valid;
   assign b_xfer   = b_valid && !hold_valid;
   assign wait_inc = {1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1};

   always_comb begin
      we_n     = 1'b0;
      wsel_n   = rf_wsel;
      wdata_n  = rf_wdata;
      stall_n  = 1'b0;
      squash_n = 1'b0;
      hv_n     = hold_valid;
      hsel_n   = hold_wsel;
      hdata_n  = hold_data;
      cnt_n    = wait_cnt;

      if (pipe_stall && hold_valid) begin
         we_n    = 1'b1;
         wsel_n  = hold_wsel;
         wdata_n = hold_data;
         hv_n    = 1'b0;
      end else if (a_we) begin
         we_n    = 1'b1;
         wsel_n  = a_wsel;
         wdata_n = a_wdata;
         if (hold_valid) begin
            if (hold_wsel == a_wsel) begin
               hv_n     = 1'b0;
               squash_n = 1'b1;
            end else begin
               if (wait_cnt != '1)
                  cnt_n = wait_inc[CNT_W-1:0];
               stall_n = (wait_inc >= LIMIT);
            end
         end else if (b_xfer) begin
            // Incoming B already overwritten by the younger A write: accept and drop.
            if (b_wsel == a_wsel) begin
               squash_n = 1'b1;
            end else begin
               hv_n    = 1'b1;
               hsel_n  = b_wsel;
               hdata_n = b_wdata;
            end
         end
      end else if (hold_valid) begin
         we_n    = 1'b1;
         wsel_n  = hold_wsel;
         wdata_n = hold_data;
         hv_n    = 1'b0;
      end else if (b_xfer) begin
         hv_n    = 1'b1;
         hsel_n  = b_wsel;
         hdata_n = b_wdata;
      end

      if (!hv_n)
         cnt_n = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_we      <= 1'b0;
         rf_wsel    <= '0;
         rf_wdata   <= '0;
         pipe_stall <= 1'b0;
         squash     <= 1'b0;
         hold_valid <= 1'b0;
         hold_wsel  <= '0;
         hold_data  <= '0;
         wait_cnt   <= '0;
      end else begin
         rf_we      <= we_n;
         rf_wsel    <= wsel_n;
         rf_wdata   <= wdata_n;
         pipe_stall <= stall_n;
         squash     <= squash_n;
         hold_valid <= hv_n;
         hold_wsel  <= hsel_n;
         hold_data  <= hdata_n;
         wait_cnt   <= cnt_n;
      end
   end

endmodule
